alu_out_stage: RTL and testbench
================================

# alu_out_stage

Registered output stage of the 4-bit ALU, directly downstream of the 2:1 operation-select mux.
- Captures each selected result with its carry/overflow, derives N and Z, and queues result+flags in a small FIFO.
- Presents the queue on a valid/ready interface and accumulates sticky carry/overflow status.
- Decouples the combinational ALU datapath from the result consumer (register file or display logic).

## Interface
Parameters:
- WIDTH, 4, result width in bits
- DEPTH, 2, FIFO entries; power of two, at least 2

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept; equals !full && !rst
- res_in  input  WIDTH  selected ALU result (the mux output)
- c_in  input  1  carry-out of selected operation
- v_in  input  1  signed overflow of selected operation
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head entry
- res_out  output  WIDTH  head result
- flags_out  output  4  head flags {N,Z,C,V}
- sticky_c  output  1  OR of C over all accepted results since clear
- sticky_v  output  1  OR of V over all accepted results since clear
- clr_sticky  input  1  clears sticky_c/sticky_v
- count  output  clog2(DEPTH)+1  occupancy

## Operation
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Stored entry: res_in, N=res_in[WIDTH-1], Z=(res_in==0), C=c_in, V=v_in.
- Flags are computed at push time and never recomputed.
- Storage is an array of DEPTH entries with wr_ptr/rd_ptr of clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
- count increments on push only, decrements on pop only, and is unchanged on simultaneous push+pop.
- full = (count==DEPTH); empty = (count==0).
- Push and pop in the same cycle are allowed at any non-full, non-empty occupancy.
- When full, in_ready=0, so no push occurs even if out_ready pops that cycle. There is no combinational ready pass-through.
- When empty, out_valid=0, so no pop occurs. res_out/flags_out are don't-care but must be stable, not X, after reset.
- Sticky update each cycle: sticky_x <= (clr_sticky ? 0 : sticky_x) | (push & x_in). On simultaneous clear and push, the pushed flag wins.
- Reset: pointers=0, count=0, out_valid=0, in_ready=0 while rst=1, sticky_c=sticky_v=0. Storage is cleared to 0, so res_out=0 and flags_out=0.
- Reset mid-operation discards all queued entries. The first cycle after rst deasserts has in_ready=1 and out_valid=0.

## Timing
- Latency: an entry pushed at edge N is visible on res_out/flags_out with out_valid=1 from just after edge N, i.e. usable in cycle N+1. The minimum path is one register stage.
- res_out/flags_out/out_valid/in_ready/count are driven only from registers. There is no combinational path from any input port to any output port, except in_ready from rst.
- Sustained throughput is one entry per cycle when out_ready is held high.
- Head data must not change while out_valid=1 && out_ready=0.

## Structure
- Shared package alu_pkg:
  - ALU_WIDTH=4
  - flag index constants FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0
  - packed alu_flags_t {n,z,c,v}
- One sub-module: alu_flag_gen, combinational, res_in/c_in/v_in -> alu_flags_t. It is reused by any later ALU status logic.
- FIFO storage, pointers and sticky logic stay inline in alu_out_stage.

## Test plan
- Reset then single push res_in=4'b0000, c=1, v=0, out_ready=0:
  - next cycle: out_valid=1, res_out=0, flags_out=4'b0110, count=1, sticky_c=1.
- Fill: push 4'b1001 (c=0, v=1) then 4'b0011 (c=0, v=0) with out_ready=0:
  - after second push: in_ready=0, count=2.
  - third in_valid is ignored.
  - then pop: head 4'b1001 with flags 4'b1001, then 4'b0011 with flags 4'b0000.
- Streaming: in_valid and out_ready high for 8 cycles with res_in=0..7:
  - out sequence 0..7 in order, one per cycle after 1-cycle latency.
  - count stays 1.
  - pointers wrap without loss.
- Backpressure: out_ready toggles 1,0,1,0 while pushing every cycle:
  - no entry dropped or duplicated.
  - head stable during each out_ready=0 cycle.
  - in_ready drops exactly when count reaches 2.
- Sticky clear collision: sticky_v=1, then clr_sticky=1 in the same cycle as a push with v_in=1:
  - sticky_v stays 1.
  - clr_sticky alone the next cycle -> sticky_v=0.
- Reset mid-operation: count=2, assert rst for 1 cycle:
  - during rst: in_ready=0.
  - after: out_valid=0, count=0, sticky bits 0, res_out=0.
  - first post-reset push appears as head.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU width, flag bit positions and the packed flag type
package alu_pkg;
  localparam int ALU_WIDTH = 4;
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;
endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: derives {N,Z,C,V} from a result and its carry/overflow
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] res,
  input  logic             c,
  input  logic             v,
  output alu_flags_t       flags
);
  assign flags = '{n: res[WIDTH-1], z: (res == '0), c: c, v: v};
endmodule

// File: rtl/alu_out_stage.sv
// alu_out_stage: registered ALU result/flag FIFO with valid/ready and sticky C/V
module alu_out_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         res_in,
  input  logic                     c_in,
  input  logic                     v_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         res_out,
  output logic [3:0]               flags_out,
  output logic                     sticky_c,
  output logic                     sticky_v,
  input  logic                     clr_sticky,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] res_mem [DEPTH];
  alu_flags_t       flg_mem [DEPTH];
  alu_flags_t       flg_new;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;
  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .res  (res_in),
    .c    (c_in),
    .v    (v_in),
    .flags(flg_new)
  );
  assign in_ready  = (count != CW'(DEPTH)) && !rst;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign res_out   = res_mem[rd_ptr];
  assign flags_out = flg_mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sticky_c <= 1'b0;
      sticky_v <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        res_mem[i] <= '0;
        flg_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        res_mem[wr_ptr] <= res_in;
        flg_mem[wr_ptr] <= flg_new;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count    <= (push && !pop) ? count + CW'(1) : (pop && !push) ? count - CW'(1) : count;
      // a flag pushed in the same cycle as a clear survives the clear
      sticky_c <= (clr_sticky ? 1'b0 : sticky_c) | (push & c_in);
      sticky_v <= (clr_sticky ? 1'b0 : sticky_v) | (push & v_in);
    end
  end
endmodule

// File: tb/tb_alu_out_stage.sv
// tb_alu_out_stage: scenario and random checks of alu_out_stage against a queue model
module tb_alu_out_stage;
  localparam int W = 4;
  localparam int D = 2;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, c_in = 0, v_in = 0, clr_sticky = 0;
  logic [W-1:0] res_in = '0;
  logic in_ready, out_valid, sticky_c, sticky_v;
  logic [W-1:0] res_out;
  logic [3:0] flags_out;
  logic [$clog2(D):0] count;
  int errs = 0, checks = 0;
  logic [W+3:0] q[$];
  bit mc, mv;
  always #5 clk = ~clk;
  alu_out_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .res_in(res_in),
    .c_in(c_in), .v_in(v_in), .out_valid(out_valid), .out_ready(out_ready),
    .res_out(res_out), .flags_out(flags_out), .sticky_c(sticky_c), .sticky_v(sticky_v),
    .clr_sticky(clr_sticky), .count(count)
  );
  function automatic logic [3:0] mflags(int r, bit c, bit v);
    return {r >= 2 ** (W - 1), r == 0, c, v};
  endfunction
  task automatic cycle(bit iv, int r, bit c, bit v, bit ordy, bit clr);
    bit push, pop;
    in_valid = iv; res_in = W'(r); c_in = c; v_in = v; out_ready = ordy; clr_sticky = clr;
    push = iv && !rst && q.size() < D;
    pop = ordy && q.size() > 0;
    @(posedge clk);
    if (rst) begin
      q.delete(); mc = 0; mv = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back({W'(r), mflags(r, c, v)});
      mc = (clr ? 1'b0 : mc) | (push & c);
      mv = (clr ? 1'b0 : mv) | (push & v);
    end
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    cycle(1, 5, 1, 1, 0, 0);
    cycle(1, 5, 1, 1, 0, 0);
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (count !== 0) begin errs++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (res_out !== 0 || flags_out !== 0) begin errs++; $display("FAIL reset_head got=%h/%b want=0/0000", res_out, flags_out); end
    checks++; if ({sticky_c, sticky_v} !== 2'b00) begin errs++; $display("FAIL reset_sticky got=%b%b want=00", sticky_c, sticky_v); end
    rst = 0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL post_reset got ir=%b ov=%b want 1/0", in_ready, out_valid); end
  endtask
  task automatic test_single();
    cycle(1, 0, 1, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || res_out !== 0) begin errs++; $display("FAIL single_head got ov=%b res=%h want 1/0", out_valid, res_out); end
    checks++; if (flags_out !== 4'b0110) begin errs++; $display("FAIL single_flags got=%b want=0110", flags_out); end
    checks++; if (count !== 1 || sticky_c !== 1'b1) begin errs++; $display("FAIL single_count_sticky got=%0d/%b want 1/1", count, sticky_c); end
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (out_valid !== 1'b0 || count !== 0) begin errs++; $display("FAIL single_drain got ov=%b cnt=%0d want 0/0", out_valid, count); end
  endtask
  task automatic test_fill();
    cycle(1, 9, 0, 1, 0, 0);
    cycle(1, 3, 0, 0, 0, 0);
    checks++; if (in_ready !== 1'b0 || count !== 2) begin errs++; $display("FAIL fill_full got ir=%b cnt=%0d want 0/2", in_ready, count); end
    cycle(1, 5, 1, 1, 0, 0);
    checks++; if (count !== 2 || res_out !== 4'd9) begin errs++; $display("FAIL fill_ignore got cnt=%0d res=%h want 2/9", count, res_out); end
    checks++; if (flags_out !== 4'b1001) begin errs++; $display("FAIL fill_head0_flags got=%b want=1001", flags_out); end
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (res_out !== 4'd3 || flags_out !== 4'b0000) begin errs++; $display("FAIL fill_head1 got=%h/%b want 3/0000", res_out, flags_out); end
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL fill_drain got ov=%b want 0", out_valid); end
  endtask
  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      cycle(1, i, 0, 0, 1, 0);
      checks++; if (out_valid !== 1'b1 || res_out !== W'(i) || count !== 1) begin
        errs++; $display("FAIL stream[%0d] got ov=%b res=%h cnt=%0d want 1/%h/1", i, out_valid, res_out, count, W'(i));
      end
    end
    cycle(0, 0, 0, 0, 1, 0);
  endtask
  task automatic test_back_to_back();
    logic [W-1:0] held;
    bit was_valid;
    for (int i = 0; i < 10; i++) begin
      bit ordy = (i % 2 == 0);
      held = res_out; was_valid = out_valid;
      cycle(1, 10 + i, i % 3 == 0, 0, ordy, 0);
      checks++; if (count !== q.size() || in_ready !== (q.size() < D) || res_out !== q[0][W+3:4]) begin
        errs++; $display("FAIL bp[%0d] got cnt=%0d ir=%b res=%h want %0d/%b/%h", i, count, in_ready, res_out, q.size(), q.size() < D, q[0][W+3:4]);
      end
      if (!ordy && was_valid) begin
        checks++; if (res_out !== held) begin errs++; $display("FAIL bp_stable[%0d] got=%h want=%h", i, res_out, held); end
      end
    end
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
  endtask
  task automatic test_sticky();
    cycle(1, 1, 0, 1, 1, 0);
    checks++; if (sticky_v !== 1'b1) begin errs++; $display("FAIL sticky_set got=%b want=1", sticky_v); end
    cycle(1, 2, 0, 1, 1, 1);
    checks++; if (sticky_v !== 1'b1) begin errs++; $display("FAIL sticky_collide got=%b want=1", sticky_v); end
    cycle(0, 0, 0, 0, 1, 1);
    checks++; if (sticky_v !== 1'b0 || sticky_c !== 1'b0) begin errs++; $display("FAIL sticky_clear got=%b%b want=00", sticky_c, sticky_v); end
  endtask
  task automatic test_reset_mid();
    cycle(1, 6, 1, 1, 0, 0);
    cycle(1, 12, 1, 0, 0, 0);
    checks++; if (count !== 2) begin errs++; $display("FAIL rmid_pre got cnt=%0d want 2", count); end
    rst = 1;
    cycle(1, 7, 1, 1, 0, 0);
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rmid_ready got=%b want=0", in_ready); end
    rst = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 0 || res_out !== 0 || sticky_c !== 1'b0 || sticky_v !== 1'b0) begin
      errs++; $display("FAIL rmid_after got ov=%b cnt=%0d res=%h st=%b%b want 0/0/0/00", out_valid, count, res_out, sticky_c, sticky_v);
    end
    cycle(1, 11, 0, 0, 0, 0);
    checks++; if (res_out !== 4'd11 || count !== 1) begin errs++; $display("FAIL rmid_first got res=%h cnt=%0d want b/1", res_out, count); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2 ** W - 1), $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
      checks++; if (out_valid !== (q.size() > 0) || count !== q.size() || in_ready !== (q.size() < D)) begin
        errs++; $display("FAIL rand_ctrl[%0d] got ov=%b cnt=%0d ir=%b want %b/%0d/%b", i, out_valid, count, in_ready, q.size() > 0, q.size(), q.size() < D);
      end
      checks++; if (sticky_c !== mc || sticky_v !== mv) begin errs++; $display("FAIL rand_sticky[%0d] got=%b%b want=%b%b", i, sticky_c, sticky_v, mc, mv); end
      if (q.size() > 0) begin
        checks++; if ({res_out, flags_out} !== q[0]) begin errs++; $display("FAIL rand_head[%0d] got=%h/%b want=%h/%b", i, res_out, flags_out, q[0][W+3:4], q[0][3:0]); end
      end else begin
        checks++; if ($isunknown({res_out, flags_out})) begin errs++; $display("FAIL rand_idle_x[%0d] got=%h/%b want known", i, res_out, flags_out); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_back_to_back();
    test_sticky();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
